// File: rtl/prepare_batch_datap.sv
// Prepare-batch datapath: validates a Prepare header against replica state, writes one header-log entry per accepted payload beat, then commits the new tails and answers.
// Latency: header accept to first header-log write is 2 cycles; a zero-wait batch of N entries raises resp_val in cycle N+3.
// Backpressure: prep_hdr_rdy only in IDLE, ent_len_rdy only in WRITE/DRAIN, resp_val held until resp_rdy. Optional stats build: PREP_BATCH_STATS_EN.
module prepare_batch_datap #(
    parameter int NOC_DATA_W      = 512,
    parameter int LOG_DEPTH_W     = 10,
    parameter int LOG_HDR_DEPTH_W = 8,
    parameter int MAX_BATCH       = 8,
    parameter int BATCH_W         = $clog2(MAX_BATCH + 1),
    parameter int LOG_W_BYTES_W   = $clog2(NOC_DATA_W / 8)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     prep_hdr_val,
    output logic                     prep_hdr_rdy,
    input  logic [63:0]              prep_hdr_view,
    input  logic [63:0]              prep_hdr_opnum,
    input  logic [BATCH_W-1:0]       prep_hdr_batch,
    input  logic [63:0]              st_curr_view,
    input  logic [63:0]              st_last_op,
    input  logic [LOG_DEPTH_W:0]     st_data_head,
    input  logic [LOG_DEPTH_W:0]     st_data_tail,
    input  logic [LOG_HDR_DEPTH_W:0] st_hdr_head,
    input  logic [LOG_HDR_DEPTH_W:0] st_hdr_tail,
    input  logic                     ent_len_val,
    output logic                     ent_len_rdy,
    input  logic [15:0]              ent_len,
    output logic                     log_hdr_wr_val,
    output logic [LOG_HDR_DEPTH_W-1:0] log_hdr_wr_addr,
    output logic [63:0]              log_hdr_wr_view,
    output logic [63:0]              log_hdr_wr_opnum,
    output logic [LOG_DEPTH_W:0]     log_hdr_wr_paddr,
    output logic [15:0]              log_hdr_wr_len,
    output logic                     st_wr_val,
    output logic [63:0]              st_wr_last_op,
    output logic [LOG_HDR_DEPTH_W:0] st_wr_hdr_tail,
    output logic [LOG_DEPTH_W:0]     st_wr_data_tail,
    output logic                     resp_val,
    input  logic                     resp_rdy,
    output logic                     resp_ok,
    output logic [63:0]              resp_opnum
`ifdef PREP_BATCH_STATS_EN
    ,
    output logic [31:0]              stat_commit_cnt,
    output logic [31:0]              stat_reject_cnt
`endif
);

    localparam int DW = LOG_DEPTH_W + 1;
    localparam logic [DW-1:0] DEPTH = DW'(1) << LOG_DEPTH_W;
    localparam logic [16:0] LINE_MASK = 17'((1 << LOG_W_BYTES_W) - 1);
    localparam logic [LOG_HDR_DEPTH_W:0] HDR_FULL_XOR = {1'b1, {LOG_HDR_DEPTH_W{1'b0}}};

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CHECK  = 3'd1;
    localparam logic [2:0] S_WRITE  = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_COMMIT = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;

    logic [2:0]               state;
    logic [63:0]              view_r, opnum_r, cview_r, last_op_r;
    logic [BATCH_W-1:0]       batch_r, idx, rem;
    logic [LOG_DEPTH_W:0]     dhead_r, dtail_acc;
    logic [LOG_HDR_DEPTH_W:0] hhead_r, htail_acc;
    logic                     ok_r;

    logic [16:0]   len_sum, lines;
    logic [DW-1:0] used, free_lines;
    logic          hdr_full, fits, beat, last_beat, check_ok;

    // Per-beat fit evaluation against the running accumulators
    always_comb begin
        len_sum    = {1'b0, ent_len} + LINE_MASK;
        lines      = len_sum >> LOG_W_BYTES_W;
        used       = dtail_acc - dhead_r;
        free_lines = DEPTH - used;
        hdr_full   = (htail_acc ^ hhead_r) == HDR_FULL_XOR;
        fits       = (32'(lines) <= 32'(free_lines)) && !hdr_full;
        beat       = (state == S_WRITE) && ent_len_val;
        last_beat  = idx == (batch_r - BATCH_W'(1));
        check_ok   = (view_r == cview_r) && (opnum_r == last_op_r + 64'd1) &&
                     (batch_r != '0) && (batch_r <= BATCH_W'(MAX_BATCH));
    end

    // Control FSM and latched batch context
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            view_r    <= '0;
            opnum_r   <= '0;
            cview_r   <= '0;
            last_op_r <= '0;
            batch_r   <= '0;
            idx       <= '0;
            rem       <= '0;
            dhead_r   <= '0;
            dtail_acc <= '0;
            hhead_r   <= '0;
            htail_acc <= '0;
            ok_r      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (prep_hdr_val) begin
                    view_r    <= prep_hdr_view;
                    opnum_r   <= prep_hdr_opnum;
                    batch_r   <= prep_hdr_batch;
                    cview_r   <= st_curr_view;
                    last_op_r <= st_last_op;
                    dhead_r   <= st_data_head;
                    dtail_acc <= st_data_tail;
                    hhead_r   <= st_hdr_head;
                    htail_acc <= st_hdr_tail;
                    idx       <= '0;
                    state     <= S_CHECK;
                end
                S_CHECK: begin
                    ok_r <= check_ok;
                    rem  <= batch_r;
                    state <= check_ok ? S_WRITE : S_DRAIN;
                end
                S_WRITE: if (ent_len_val) begin
                    if (fits) begin
                        dtail_acc <= dtail_acc + DW'(lines);
                        htail_acc <= htail_acc + 1'b1;
                        idx       <= idx + BATCH_W'(1);
                        if (last_beat) state <= S_COMMIT;
                    end else begin
                        // Abort: whatever beats remain still have to be consumed
                        ok_r  <= 1'b0;
                        rem   <= batch_r - idx - BATCH_W'(1);
                        state <= last_beat ? S_RESP : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (rem == '0) begin
                        state <= S_RESP;
                    end else if (ent_len_val) begin
                        rem <= rem - BATCH_W'(1);
                        if (rem == BATCH_W'(1)) state <= S_RESP;
                    end
                end
                S_COMMIT: state <= S_RESP;
                S_RESP:   if (resp_rdy) state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // Handshake and data outputs; everything forced low while rst is high
    always_comb begin
        prep_hdr_rdy     = !rst && (state == S_IDLE);
        ent_len_rdy      = !rst && ((state == S_WRITE) || ((state == S_DRAIN) && (rem != '0)));
        log_hdr_wr_val   = !rst && beat && fits;
        log_hdr_wr_addr  = log_hdr_wr_val ? htail_acc[LOG_HDR_DEPTH_W-1:0] : '0;
        log_hdr_wr_view  = log_hdr_wr_val ? view_r : '0;
        log_hdr_wr_opnum = log_hdr_wr_val ? opnum_r + 64'(idx) : '0;
        log_hdr_wr_paddr = log_hdr_wr_val ? dtail_acc : '0;
        log_hdr_wr_len   = log_hdr_wr_val ? ent_len : '0;
        st_wr_val        = !rst && (state == S_COMMIT);
        st_wr_last_op    = st_wr_val ? last_op_r + 64'(batch_r) : '0;
        st_wr_hdr_tail   = st_wr_val ? htail_acc : '0;
        st_wr_data_tail  = st_wr_val ? dtail_acc : '0;
        resp_val         = !rst && (state == S_RESP);
        resp_ok          = resp_val && ok_r;
        resp_opnum       = !resp_val ? 64'd0 :
                           ok_r ? opnum_r + 64'(batch_r) - 64'd1 : last_op_r;
    end

`ifdef PREP_BATCH_STATS_EN
    // Saturating commit / reject counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_commit_cnt <= '0;
            stat_reject_cnt <= '0;
        end else begin
            if (st_wr_val && (stat_commit_cnt != '1))
                stat_commit_cnt <= stat_commit_cnt + 32'd1;
            if (resp_val && resp_rdy && !ok_r && (stat_reject_cnt != '1))
                stat_reject_cnt <= stat_reject_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_prepare_batch_datap.sv
// Bench for prepare_batch_datap: table of Prepare batches with hand-derived outcomes,
// header writes predicted by a small log model, plus a mid-batch reset sequence.
module tb_prepare_batch_datap;

    logic        clk = 1'b0;
    logic        rst;
    logic        prep_hdr_val, prep_hdr_rdy;
    logic [63:0] prep_hdr_view, prep_hdr_opnum;
    logic [3:0]  prep_hdr_batch;
    logic [63:0] st_curr_view, st_last_op;
    logic [10:0] st_data_head, st_data_tail;
    logic [8:0]  st_hdr_head, st_hdr_tail;
    logic        ent_len_val, ent_len_rdy;
    logic [15:0] ent_len;
    logic        log_hdr_wr_val;
    logic [7:0]  log_hdr_wr_addr;
    logic [63:0] log_hdr_wr_view, log_hdr_wr_opnum;
    logic [10:0] log_hdr_wr_paddr;
    logic [15:0] log_hdr_wr_len;
    logic        st_wr_val;
    logic [63:0] st_wr_last_op;
    logic [8:0]  st_wr_hdr_tail;
    logic [10:0] st_wr_data_tail;
    logic        resp_val, resp_rdy, resp_ok;
    logic [63:0] resp_opnum;

    always #5 clk = ~clk;

    prepare_batch_datap dut (
        .clk(clk), .rst(rst),
        .prep_hdr_val(prep_hdr_val), .prep_hdr_rdy(prep_hdr_rdy),
        .prep_hdr_view(prep_hdr_view), .prep_hdr_opnum(prep_hdr_opnum),
        .prep_hdr_batch(prep_hdr_batch),
        .st_curr_view(st_curr_view), .st_last_op(st_last_op),
        .st_data_head(st_data_head), .st_data_tail(st_data_tail),
        .st_hdr_head(st_hdr_head), .st_hdr_tail(st_hdr_tail),
        .ent_len_val(ent_len_val), .ent_len_rdy(ent_len_rdy), .ent_len(ent_len),
        .log_hdr_wr_val(log_hdr_wr_val), .log_hdr_wr_addr(log_hdr_wr_addr),
        .log_hdr_wr_view(log_hdr_wr_view), .log_hdr_wr_opnum(log_hdr_wr_opnum),
        .log_hdr_wr_paddr(log_hdr_wr_paddr), .log_hdr_wr_len(log_hdr_wr_len),
        .st_wr_val(st_wr_val), .st_wr_last_op(st_wr_last_op),
        .st_wr_hdr_tail(st_wr_hdr_tail), .st_wr_data_tail(st_wr_data_tail),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_ok(resp_ok),
        .resp_opnum(resp_opnum)
    );

    typedef struct {
        logic [63:0] view, opnum, cv, last;
        int          batch;
        int          lens [4];
        int          dh, dt, hh, ht;
        bit          e_ok;
        logic [63:0] e_op;
        bit          e_st;
        logic [63:0] e_last;
        int          e_ht, e_dt, e_lat;
    } vec_t;

    typedef struct packed { logic [7:0] addr; logic [63:0] view; logic [63:0] op; logic [10:0] paddr; logic [15:0] len; } hw_t;
    typedef struct packed { logic [63:0] last; logic [8:0] ht; logic [10:0] dt; } sw_t;
    typedef struct packed { logic ok; logic [63:0] op; } rs_t;

    hw_t hq[$];
    sw_t sq[$];
    rs_t rq[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int exp_lat = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: every DUT output event is matched against the scoreboard
    always @(negedge clk) begin
        if (prep_hdr_val && prep_hdr_rdy) acc_cyc = cyc;
        if (log_hdr_wr_val) begin
            if (hq.size() == 0) chk("hdr_unexpected", {56'd0, log_hdr_wr_addr}, 64'hDEAD);
            else begin
                hw_t e;
                e = hq.pop_front();
                chk("hdr_addr", {56'd0, log_hdr_wr_addr}, {56'd0, e.addr});
                chk("hdr_view", log_hdr_wr_view, e.view);
                chk("hdr_opnum", log_hdr_wr_opnum, e.op);
                chk("hdr_paddr", {53'd0, log_hdr_wr_paddr}, {53'd0, e.paddr});
                chk("hdr_len", {48'd0, log_hdr_wr_len}, {48'd0, e.len});
            end
        end
        if (st_wr_val) begin
            if (sq.size() == 0) chk("st_unexpected", st_wr_last_op, 64'hDEAD);
            else begin
                sw_t e;
                e = sq.pop_front();
                chk("st_last_op", st_wr_last_op, e.last);
                chk("st_hdr_tail", {55'd0, st_wr_hdr_tail}, {55'd0, e.ht});
                chk("st_data_tail", {53'd0, st_wr_data_tail}, {53'd0, e.dt});
            end
        end
        if (resp_val && resp_rdy) begin
            if (rq.size() == 0) chk("resp_unexpected", resp_opnum, 64'hDEAD);
            else begin
                rs_t e;
                e = rq.pop_front();
                chk("resp_ok", {63'd0, resp_ok}, {63'd0, e.ok});
                chk("resp_opnum", resp_opnum, e.op);
                if (exp_lat != 0) chk("latency", 64'(cyc - acc_cyc), 64'(exp_lat));
            end
        end
    end

    function automatic vec_t mk(input logic [63:0] view, opnum, cv, last, input int batch,
                                input int l0, l1, l2, l3, input int dh, dt, hh, ht,
                                input bit eok, input logic [63:0] eop, input bit est,
                                input logic [63:0] elast, input int eht, edt, elat);
        vec_t v;
        v.view = view; v.opnum = opnum; v.cv = cv; v.last = last; v.batch = batch;
        v.lens[0] = l0; v.lens[1] = l1; v.lens[2] = l2; v.lens[3] = l3;
        v.dh = dh; v.dt = dt; v.hh = hh; v.ht = ht;
        v.e_ok = eok; v.e_op = eop; v.e_st = est; v.e_last = elast;
        v.e_ht = eht; v.e_dt = edt; v.e_lat = elat;
        return v;
    endfunction

    // Log model: predict which beats get a header-log entry
    task automatic predict_writes(input vec_t v);
        int dt, ht, lines, used;
        bit okc;
        okc = (v.view == v.cv) && (v.opnum == v.last + 64'd1) && (v.batch >= 1) && (v.batch <= 8);
        if (!okc) return;
        dt = v.dt; ht = v.ht;
        for (int i = 0; i < v.batch; i++) begin
            lines = (v.lens[i % 4] + 63) / 64;
            used  = (dt - v.dh) & 2047;
            if ((lines > 1024 - used) || (((ht ^ v.hh) & 511) == 256)) break;
            hq.push_back('{addr: 8'(ht), view: v.view, op: v.opnum + 64'(i), paddr: 11'(dt), len: 16'(v.lens[i % 4])});
            dt = (dt + lines) & 2047;
            ht = (ht + 1) & 511;
        end
    endtask

    task automatic send_hdr(input vec_t v);
        bit got;
        @(posedge clk); #1;
        prep_hdr_view = v.view; prep_hdr_opnum = v.opnum; prep_hdr_batch = 4'(v.batch);
        st_curr_view = v.cv; st_last_op = v.last;
        st_data_head = 11'(v.dh); st_data_tail = 11'(v.dt);
        st_hdr_head = 9'(v.hh); st_hdr_tail = 9'(v.ht);
        prep_hdr_val = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = prep_hdr_rdy;
        end
        chk("hdr_accept", {63'd0, got}, 64'd1);
        @(posedge clk); #1;
        prep_hdr_val = 1'b0;
    endtask

    task automatic send_beat(input int len);
        bit got;
        ent_len_val = 1'b1;
        ent_len = 16'(len);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = ent_len_rdy;
        end
        if (!got) chk("beat_accept", 64'd0, 64'd1);
        @(posedge clk); #1;
        ent_len_val = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        exp_lat = v.e_lat;
        predict_writes(v);
        if (v.e_st) sq.push_back('{last: v.e_last, ht: 9'(v.e_ht), dt: 11'(v.e_dt)});
        rq.push_back('{ok: v.e_ok, op: v.e_op});
        send_hdr(v);
        for (int i = 0; i < v.batch; i++) send_beat(v.lens[i % 4]);
        for (int k = 0; k < 60 && rq.size() != 0; k++) begin
            @(posedge clk); #2;
        end
        chk("resp_left", 64'(rq.size()), 64'd0);
        @(posedge clk); #2;
        chk("hdr_left", 64'(hq.size()), 64'd0);
        chk("st_left", 64'(sq.size()), 64'd0);
        hq.delete(); sq.delete(); rq.delete();
        exp_lat = 0;
    endtask

    vec_t vt [12];

    initial begin
        //        view opnum cv last b   lens              dh    dt    hh   ht   ok op   st last ht  dt   lat
        vt[0]  = mk(3, 10, 3, 9, 3,  64, 0, 65, 0,       0,    100,  0,   5,   1, 12, 1, 12, 8,  103, 6);
        vt[1]  = mk(3, 12, 3, 9, 2,  64, 64, 0, 0,       0,    0,    0,   0,   0, 9,  0, 0,  0,  0,   0);
        vt[2]  = mk(3, 10, 3, 9, 2,  64, 64, 0, 0,       0,    1023, 0,   0,   0, 9,  0, 0,  0,  0,   0);
        vt[3]  = mk(3, 10, 3, 9, 2,  10, 10, 0, 0,       0,    0,    200, 255, 1, 11, 1, 11, 257, 2,  0);
        vt[4]  = mk(4, 10, 3, 9, 1,  64, 0, 0, 0,        0,    0,    0,   0,   0, 9,  0, 0,  0,  0,   0);
        vt[5]  = mk(3, 10, 3, 9, 0,  0, 0, 0, 0,         0,    0,    0,   0,   0, 9,  0, 0,  0,  0,   0);
        vt[6]  = mk(3, 10, 3, 9, 9,  1, 2, 3, 4,         0,    0,    0,   0,   0, 9,  0, 0,  0,  0,   0);
        vt[7]  = mk(3, 10, 3, 9, 1,  1, 0, 0, 0,         0,    0,    0,   256, 0, 9,  0, 0,  0,  0,   0);
        vt[8]  = mk(3, 10, 3, 9, 2,  128, 128, 0, 0,     1026, 2046, 0,   0,   1, 11, 1, 11, 2,  2,   0);
        vt[9]  = mk(3, 10, 3, 9, 8,  1, 1, 1, 1,         0,    0,    0,   0,   1, 17, 1, 17, 8,  8,   11);
        vt[10] = mk(7, 101, 7, 100, 1, 0, 0, 0, 0,       0,    1024, 0,   0,   1, 101, 1, 101, 1, 1024, 0);
        vt[11] = mk(64'hFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFF, 64'hFFFFFFFFFFFFFFFE, 1, 200, 0, 0, 0,
                    0, 0, 0, 0, 1, 64'hFFFFFFFFFFFFFFFF, 1, 64'hFFFFFFFFFFFFFFFF, 1, 4, 0);

        rst = 1'b1; resp_rdy = 1'b1;
        prep_hdr_val = 1'b0; prep_hdr_view = '0; prep_hdr_opnum = '0; prep_hdr_batch = '0;
        st_curr_view = '0; st_last_op = '0; st_data_head = '0; st_data_tail = '0;
        st_hdr_head = '0; st_hdr_tail = '0; ent_len_val = 1'b0; ent_len = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hdr_rdy", {63'd0, prep_hdr_rdy}, 64'd0);
        chk("rst_ent_rdy", {63'd0, ent_len_rdy}, 64'd0);
        chk("rst_hdr_wr", {63'd0, log_hdr_wr_val}, 64'd0);
        chk("rst_st_wr", {63'd0, st_wr_val}, 64'd0);
        chk("rst_resp", {62'd0, resp_val, resp_ok}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_hdr_rdy", {63'd0, prep_hdr_rdy}, 64'd1);

        for (int i = 0; i < 12; i++) run_vec(vt[i]);

        // Reset in the middle of a 4-beat batch, during the second beat
        begin
            vec_t v;
            v = mk(3, 10, 3, 9, 4, 64, 64, 64, 64, 0, 20, 0, 30, 1, 13, 1, 13, 34, 24, 0);
            hq.push_back('{addr: 8'd30, view: 64'd3, op: 64'd10, paddr: 11'd20, len: 16'd64});
            send_hdr(v);
            send_beat(64);
            ent_len_val = 1'b1; ent_len = 16'd64; rst = 1'b1;
            @(negedge clk);
            chk("mid_rst_ent_rdy", {63'd0, ent_len_rdy}, 64'd0);
            chk("mid_rst_hdr_wr", {63'd0, log_hdr_wr_val}, 64'd0);
            chk("mid_rst_hdr_rdy", {63'd0, prep_hdr_rdy}, 64'd0);
            @(posedge clk); #1;
            rst = 1'b0; ent_len_val = 1'b0;
            @(negedge clk);
            chk("post_rst_idle", {63'd0, prep_hdr_rdy}, 64'd1);
            chk("post_rst_hdr_left", 64'(hq.size()), 64'd0);
            repeat (4) @(posedge clk);
            #2;
            chk("post_rst_no_resp", 64'(rq.size()), 64'd0);
            run_vec(vt[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/prepare_batch_datap.md
PREPARE_BATCH_DATAP -- requirements
Module: prepare_batch_datap

Interface
REQ-001 Parameter NOC_DATA_W, default 512; NoC data width, used only for line-size derivation.
REQ-002 Parameter LOG_DEPTH_W, default 10; data-log depth 2^LOG_DEPTH_W lines; data pointers carry one extra wrap bit.
REQ-003 Parameter LOG_HDR_DEPTH_W, default 8; header-log depth 2^LOG_HDR_DEPTH_W; header pointers carry one extra wrap bit.
REQ-004 Parameter MAX_BATCH, default 8; maximum entries per Prepare; BATCH_W = $clog2(MAX_BATCH+1).
REQ-005 Parameter LOG_W_BYTES_W, default $clog2(NOC_DATA_W/8); log2 of bytes per data-log line.
REQ-006 clk  in  1  clock; one clock domain only.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 prep_hdr_val/prep_hdr_rdy  in/out  1/1  Prepare header handshake.
REQ-009 prep_hdr_view, prep_hdr_opnum  in  64 each  view and first op number of the batch.
REQ-010 prep_hdr_batch  in  BATCH_W  entry count.
REQ-011 st_curr_view, st_last_op  in  64 each  replica state, sampled at header accept.
REQ-012 st_data_head, st_data_tail  in  LOG_DEPTH_W+1 each; st_hdr_head, st_hdr_tail  in  LOG_HDR_DEPTH_W+1 each.
REQ-013 ent_len_val/ent_len_rdy  in/out  1/1; ent_len  in  16  per-entry payload byte length, one beat per entry.
REQ-014 log_hdr_wr_val  out  1; log_hdr_wr_addr  out  LOG_HDR_DEPTH_W; log_hdr_wr_view/opnum  out  64; log_hdr_wr_paddr  out  LOG_DEPTH_W+1; log_hdr_wr_len  out  16.
REQ-015 st_wr_val  out  1; st_wr_last_op  out  64; st_wr_hdr_tail, st_wr_data_tail  out  pointer widths.
REQ-016 resp_val/resp_rdy  out/in  1/1; resp_ok  out  1; resp_opnum  out  64  last op of batch.

Function
REQ-017 FSM states IDLE, CHECK, WRITE, DRAIN, COMMIT, RESP; prep_hdr_rdy=1 only in IDLE.
REQ-018 IDLE: on prep_hdr_val, latch header and all st_* inputs, go CHECK.
REQ-019 CHECK (1 cycle): ok = view==curr_view, opnum==last_op+1, 1<=batch<=MAX_BATCH; ok -> WRITE, else -> DRAIN with resp_ok=0.
REQ-020 WRITE: ent_len_rdy=1; per beat lines=ceil(ent_len/2^LOG_W_BYTES_W) (0 for length 0); header-log full = tail^head equal to MSB-only difference.
REQ-021 Beat fits if lines <= 2^LOG_DEPTH_W-(data_tail_acc-data_head) (LOG_DEPTH_W+1-bit modular) and header log not full; then same cycle log_hdr_wr_val=1, addr=hdr_tail_acc[LOG_HDR_DEPTH_W-1:0], opnum=opnum+i, paddr=data_tail_acc, len=ent_len.
REQ-022 Accumulators advance modulo their widths (wrap bit toggles on wrap); after beat batch-1 -> COMMIT.
REQ-023 Beat does not fit: no header write, resp_ok=0, -> DRAIN (or COMMIT-less RESP if last beat).
REQ-024 DRAIN: ent_len_rdy=1, discard remaining beats of the batch (all batch beats when CHECK failed; none if batch=0), then -> RESP.
REQ-025 COMMIT (1 cycle): st_wr_val=1, last_op=latched last_op+batch, tails = accumulators; resp_ok=1, -> RESP.
REQ-026 RESP: resp_val=1 until resp_rdy; resp_opnum=opnum+batch-1 (ok) or latched last_op (rejected); -> IDLE.
REQ-027 Rejected or aborted batches never assert st_wr_val; orphan header writes beyond committed tail are permitted.
REQ-028 Header latency: header accept to first possible write = 2 cycles; zero-wait batch of N completes response at cycle N+3.

Reset
REQ-029 rst mid-operation returns FSM to IDLE next cycle, clearing accumulators and counters; in-flight batch discarded without state write.
REQ-030 Under reset all val outputs, ent_len_rdy, resp_ok = 0; prep_hdr_rdy = 0 while rst high; data outputs 0.

Configuration
REQ-031 Macro PREP_BATCH_STATS_EN: when defined, adds outputs stat_commit_cnt and stat_reject_cnt (32 bits, saturating, cleared by rst), incremented on COMMIT and on RESP with resp_ok=0.
REQ-032 Without PREP_BATCH_STATS_EN those ports and counters do not exist; all other behaviour identical.

Verification
REQ-033 view=3, last_op=9, header opnum=10, batch=3, lens 64/0/65 -> headers at tail, tail+1, tail+2, paddr +0/+1/+1, st_wr_last_op=12, data tail+3, resp_ok=1, resp_opnum=12.
REQ-034 opnum=12 with last_op=9, batch=2 -> both beats drained, no header/state write, resp_ok=0, resp_opnum=9.
REQ-035 data log 1 line free, batch=2, lens 64/64 -> first header written, second rejected, no st_wr_val, resp_ok=0.
REQ-036 hdr_tail=255 (wrap bit 0) depth 256, batch=2 -> addrs 255 then 0, st_wr_hdr_tail wrap bit set.
REQ-037 rst asserted during WRITE beat 2 of 4 -> IDLE next cycle, no st_wr_val, next header accepted normally.
